mul_share_arbiter: RTL and testbench

Shares one pipelined 32x32 multiplier (vedic32x32 datapath, fixed latency MUL_LAT) between NREQ requesters.
- Each requester has a valid/ready operand port and a valid/ready result port.
- Grants are round-robin, at most one issue per cycle.
- A tag pipeline tracks which requester owns each in-flight product, and the product is returned to that requester.
- Sits between the matrix-multiply element engines and the single shared multiplier instance.

---
 rtl/mul_share_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mul_share_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
// Shares one external pipelined 32x32 unsigned multiplier between NREQ
// requesters. A round-robin arbiter issues at most one operand pair per
// cycle. A tag pipeline follows each product through the multiplier latency
// and steers it into the owning requester's result register.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   req_valid/req_ready  per-requester operand handshake (req_ready = grant)
//   req_a, req_b         packed operands, requester i at [32i+31:32i]
//   rsp_valid/rsp_ready  per-requester product handshake
//   rsp_data             packed products, requester i at [64i+63:64i]
//   mul_a, mul_b         registered operands to the shared multiplier
//   mul_result           multiplier product, MUL_LAT cycles after mul_a/mul_b
//   busy                 any requester has an operation outstanding

module mul_share_arbiter_chk #(
  parameter int NREQ = 4
) (
  input logic            clk,
  input logic            rst,
  input logic [NREQ-1:0] grant,
  input logic [NREQ-1:0] pend,
  input logic [NREQ-1:0] land,
  input logic [NREQ-1:0] rsp_valid
);
  // A requester with an outstanding operation must never be granted again.
  a_no_grant_when_pend: assert property (@(posedge clk) disable iff (rst)
    (grant & pend) == '0);
  // A product must never land on a result register that is still full.
  a_no_land_when_full: assert property (@(posedge clk) disable iff (rst)
    (land & rsp_valid) == '0);
endmodule

module mul_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 3,
  parameter int IDXW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [64*NREQ-1:0]   rsp_data,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [63:0]          mul_result,
  output logic                 busy
);

  logic [IDXW-1:0]  ptr_r;
  logic [NREQ-1:0]  pend_r;
  logic [NREQ-1:0]  elig_s;
  logic [NREQ-1:0]  grant_s;
  logic [IDXW-1:0]  gidx_s;
  logic [IDXW-1:0]  idx_s;
  logic             found_s;
  logic [31:0]      a_arr_s [NREQ];
  logic [31:0]      b_arr_s [NREQ];
  logic [31:0]      mul_a_r;
  logic [31:0]      mul_b_r;
  logic [MUL_LAT:0] tag_v_r;
  logic [IDXW-1:0]  tag_k_r [MUL_LAT+1];
  logic [NREQ-1:0]  land_s;
  logic [NREQ-1:0]  hs_s;
  logic [NREQ-1:0]  rsp_valid_r;
  logic [63:0]      rsp_data_r [NREQ];

  // Unpack the operand and result buses into per-requester lanes.
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign a_arr_s[i]              = req_a[32*i +: 32];
    assign b_arr_s[i]              = req_b[32*i +: 32];
    assign rsp_data[64*i +: 64]    = rsp_data_r[i];
    assign land_s[i]               = tag_v_r[MUL_LAT] & (tag_k_r[MUL_LAT] == IDXW'(i));
    assign hs_s[i]                 = rsp_valid_r[i] & rsp_ready[i];
  end

  // One outstanding op per requester keeps its result register free for the landing product.
  assign elig_s = req_valid & ~pend_r;

  // Round-robin search from ptr upward (mod NREQ); first eligible requester wins.
  always_comb begin
    grant_s = '0;
    gidx_s  = '0;
    idx_s   = '0;
    found_s = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      if ((int'(ptr_r) + off) >= NREQ) begin
        idx_s = IDXW'(int'(ptr_r) + off - NREQ);
      end else begin
        idx_s = IDXW'(int'(ptr_r) + off);
      end
      if (!found_s && elig_s[idx_s]) begin
        found_s = 1'b1;
        gidx_s  = idx_s;
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      grant_s[gidx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // Pointer advance, operand issue and tag pipeline shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r   <= '0;
      mul_a_r <= '0;
      mul_b_r <= '0;
      tag_v_r <= '0;
      for (int j = 0; j <= MUL_LAT; j++) begin
        tag_k_r[j] <= '0;
      end
    end else begin
      if (found_s) begin
        if (int'(gidx_s) == NREQ - 1) begin
          ptr_r <= '0;
        end else begin
          ptr_r <= gidx_s + IDXW'(1);
        end
        mul_a_r <= a_arr_s[gidx_s];
        mul_b_r <= b_arr_s[gidx_s];
      end
      // A bubble (valid 0) enters whenever nothing is granted.
      tag_v_r    <= {tag_v_r[MUL_LAT-1:0], found_s};
      tag_k_r[0] <= gidx_s;
      for (int j = 1; j <= MUL_LAT; j++) begin
        tag_k_r[j] <= tag_k_r[j-1];
      end
    end
  end

  // Result capture, response handshake and outstanding-op tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r      <= '0;
      rsp_valid_r <= '0;
      for (int i = 0; i < NREQ; i++) begin
        rsp_data_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (land_s[i]) begin
          rsp_valid_r[i] <= 1'b1;
          rsp_data_r[i]  <= mul_result;
        end else if (hs_s[i]) begin
          rsp_valid_r[i] <= 1'b0;
          rsp_data_r[i]  <= '0;
        end
        // Grant and handshake never coincide on one requester: grant needs pend=0.
        pend_r[i] <= (pend_r[i] & ~hs_s[i]) | grant_s[i];
      end
    end
  end

  assign req_ready = grant_s;
  assign rsp_valid = rsp_valid_r;
  assign mul_a     = mul_a_r;
  assign mul_b     = mul_b_r;
  assign busy      = |pend_r;

  mul_share_arbiter_chk #(.NREQ(NREQ)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .grant     (grant_s),
    .pend      (pend_r),
    .land      (land_s),
    .rsp_valid (rsp_valid_r)
  );

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed testbench for mul_share_arbiter with a behavioural MUL_LAT-stage
// multiplier. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge.
module tb_mul_share_arbiter;
  localparam int NREQ = 4;
  localparam int MUL_LAT = 3;
  localparam int IDXW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [32*NREQ-1:0] req_a = '0;
  logic [32*NREQ-1:0] req_b = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready = '0;
  logic [64*NREQ-1:0] rsp_data;
  logic [31:0]       mul_a;
  logic [31:0]       mul_b;
  logic [63:0]       mul_result;
  logic              busy;
  logic [63:0]       mpipe [MUL_LAT];

  int checks = 0;
  int failures = 0;

  mul_share_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference multiplier: product appears MUL_LAT cycles after operands.
  always @(posedge clk) begin
    mpipe[0] <= {32'd0, mul_a} * {32'd0, mul_b};
    for (int s = 1; s < MUL_LAT; s++) mpipe[s] <= mpipe[s-1];
  end
  assign mul_result = mpipe[MUL_LAT-1];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000 || busy !== 1'b0 ||
          mul_a !== 32'd0 || mul_b !== 32'd0) begin
        failures++;
        $display("FAIL idle c=%0d: rdy=%b rsp_valid=%b busy=%b mul_a=%h mul_b=%h, required all zero",
                 c, req_ready, rsp_valid, busy, mul_a, mul_b);
      end
      cyc();
    end
  endtask

  task automatic test_single();
    logic [3:0] er;
    logic [3:0] ev;
    logic       eb;
    do_reset();
    rsp_ready = 4'b0001;
    req_a[31:0] = 32'hFFFF_FFFF;
    req_b[31:0] = 32'hFFFF_FFFF;
    for (int k = 0; k < 8; k++) begin
      req_valid = (k == 0) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      er = (k == 0) ? 4'b0001 : 4'b0000;
      ev = (k == 5) ? 4'b0001 : 4'b0000;
      eb = (k >= 1 && k <= 5);
      checks++;
      if (req_ready !== er) begin
        failures++;
        $display("FAIL single_ready k=%0d: got %b required %b", k, req_ready, er);
      end
      checks++;
      if (busy !== eb) begin
        failures++;
        $display("FAIL single_busy k=%0d: got %b required %b", k, busy, eb);
      end
      checks++;
      if (rsp_valid !== ev) begin
        failures++;
        $display("FAIL single_rsp_valid k=%0d: got %b required %b", k, rsp_valid, ev);
      end
      if (k == 1) begin
        checks++;
        if (mul_a !== 32'hFFFF_FFFF || mul_b !== 32'hFFFF_FFFF) begin
          failures++;
          $display("FAIL single_operands: got %h/%h required ffffffff/ffffffff", mul_a, mul_b);
        end
      end
      if (k == 5) begin
        checks++;
        if (rsp_data[63:0] !== 64'hFFFF_FFFE_0000_0001) begin
          failures++;
          $display("FAIL single_data: got %h required fffffffe00000001", rsp_data[63:0]);
        end
      end
      cyc();
    end
  endtask

  task automatic test_all_four();
    logic [3:0]  mask;
    logic [3:0]  er;
    logic [3:0]  ev;
    logic [63:0] ed;
    do_reset();
    rsp_ready = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = 32'(i + 1);
      req_b[32*i +: 32] = 32'h10;
    end
    mask = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      req_valid = mask;
      @(negedge clk);
      er = (k < 4) ? (4'b0001 << k) : 4'b0000;
      ev = (k >= 5 && k <= 8) ? (4'b0001 << (k - 5)) : 4'b0000;
      checks++;
      if (req_ready !== er) begin
        failures++;
        $display("FAIL four_grant k=%0d: got %b required %b", k, req_ready, er);
      end
      checks++;
      if (rsp_valid !== ev) begin
        failures++;
        $display("FAIL four_rsp_valid k=%0d: got %b required %b", k, rsp_valid, ev);
      end
      if (k >= 5 && k <= 8) begin
        ed = 64'((k - 4) * 16);
        checks++;
        if (rsp_data[(k-5)*64 +: 64] !== ed) begin
          failures++;
          $display("FAIL four_data req%0d: got %h required %h", k - 5, rsp_data[(k-5)*64 +: 64], ed);
        end
      end
      if (k < 4) mask[k] = 1'b0;
      cyc();
    end
  endtask

  task automatic test_backpressure();
    int g [NREQ];
    bit seen2;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = 32'(i + 2);
      req_b[32*i +: 32] = 32'd3;
      g[i] = 0;
    end
    seen2 = 1'b0;
    rsp_ready = 4'b1011;
    req_valid = 4'b1111;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++;
      if (!$onehot0(req_ready)) begin
        failures++;
        $display("FAIL bp_onehot c=%0d: got %b required one-hot or zero", c, req_ready);
      end
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) g[i]++;
      if (seen2 || rsp_valid[2]) begin
        checks++;
        if (rsp_valid[2] !== 1'b1 || rsp_data[191:128] !== 64'd12) begin
          failures++;
          $display("FAIL bp_hold c=%0d: valid=%b data=%h required 1/000000000000000c",
                   c, rsp_valid[2], rsp_data[191:128]);
        end
        seen2 = 1'b1;
      end
      cyc();
    end
    checks++;
    if (g[2] != 1 || !seen2) begin
      failures++;
      $display("FAIL bp_grant2: grants=%0d seen=%0d required 1/1", g[2], seen2);
    end
    checks++;
    if (g[0] < 3 || g[1] < 3 || g[3] < 3) begin
      failures++;
      $display("FAIL bp_others: grants %0d/%0d/%0d required each >= 3", g[0], g[1], g[3]);
    end
    req_valid = 4'b0100;
    rsp_ready = 4'b1111;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL bp_release_same: got %b required 0000", req_ready);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL bp_release_next: got %b required 0100", req_ready);
    end
    cyc();
    req_valid = 4'b0000;
  endtask

  task automatic test_fairness();
    logic [3:0] er;
    logic [3:0] ev;
    do_reset();
    rsp_ready = 4'b1111;
    req_a[31:0] = 32'd5;
    req_b[31:0] = 32'd7;
    req_a[63:32] = 32'd6;
    req_b[63:32] = 32'd7;
    for (int c = 0; c < 200; c++) begin
      req_valid = 4'b0011;
      @(negedge clk);
      er = (c % 6 == 0) ? 4'b0001 : ((c % 6 == 1) ? 4'b0010 : 4'b0000);
      ev = (c % 6 == 5) ? 4'b0001 : ((c % 6 == 0 && c >= 6) ? 4'b0010 : 4'b0000);
      checks++;
      if (req_ready !== er) begin
        failures++;
        $display("FAIL fair_grant c=%0d: got %b required %b", c, req_ready, er);
      end
      checks++;
      if (rsp_valid !== ev) begin
        failures++;
        $display("FAIL fair_rsp c=%0d: got %b required %b", c, rsp_valid, ev);
      end
      if (ev[0]) begin
        checks++;
        if (rsp_data[63:0] !== 64'd35) begin
          failures++;
          $display("FAIL fair_data0 c=%0d: got %h required 23", c, rsp_data[63:0]);
        end
      end
      if (ev[1]) begin
        checks++;
        if (rsp_data[127:64] !== 64'd42) begin
          failures++;
          $display("FAIL fair_data1 c=%0d: got %h required 2a", c, rsp_data[127:64]);
        end
      end
      cyc();
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_ready = 4'b1111;
    req_a[127:96] = 32'd9;
    req_b[127:96] = 32'd9;
    req_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL mid_grant3: got %b required 1000", req_ready);
    end
    cyc();
    req_valid = 4'b0000;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mul_a !== 32'd9) begin
      failures++;
      $display("FAIL mid_issue: busy=%b mul_a=%h required 1/00000009", busy, mul_a);
    end
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0000 || busy !== 1'b0 || mul_a !== 32'd0) begin
        failures++;
        $display("FAIL mid_after k=%0d: rsp_valid=%b busy=%b mul_a=%h required 0000/0/0",
                 k, rsp_valid, busy, mul_a);
      end
      cyc();
    end
    // Leave ptr at 2 via a grant to 1, then reset: lowest valid index must win.
    req_a[63:32] = 32'd1;
    req_b[63:32] = 32'd1;
    req_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL mid_grant1: got %b required 0010", req_ready);
    end
    cyc();
    req_valid = 4'b0000;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req_valid = 4'b0110;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL mid_ptr_reset: got %b required 0010", req_ready);
    end
    cyc();
    req_valid = 4'b0000;
  endtask

  initial begin
    cyc();
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
